// File: rtl/fme_pkg.sv
// Shared FME constants: pixel/half-pel widths and the six-tap half-pel filter taps.
package fme_pkg;
  localparam int FME_PIX_W  = 8;
  localparam int FME_HPEL_W = FME_PIX_W + 3;

  // Symmetric taps: t0*(w0+w5) + t1*(w1+w4) + t2*(w2+w3)
  localparam int FIR_T0     = 1;
  localparam int FIR_T1     = -5;
  localparam int FIR_T2     = 20;
  localparam int FIR_ROUND  = 16;
  localparam int FIR_SHIFT  = 5;

  localparam int FIR_TAPS   = 6;
  localparam int FIR_STAGES = 2;
endpackage

// File: rtl/fir6_mac.sv
// Combinational tap combine for the half-pel filter: sum = p0 - 5*p1 + 20*p2.
// Multiplies are shift-adds (5x = 4x + x, 20x = 16x + 4x).
module fir6_mac #(
  parameter int PW = 9,
  parameter int AW = 16
) (
  input  logic [PW-1:0]        p0,
  input  logic [PW-1:0]        p1,
  input  logic [PW-1:0]        p2,
  output logic signed [AW-1:0] sum
);
  logic signed [AW-1:0] e0, e1, e2;

  assign e0  = AW'(p0);
  assign e1  = AW'(p1);
  assign e2  = AW'(p2);
  assign sum = e0 - ((e1 <<< 2) + e1) + ((e2 <<< 4) + (e2 <<< 2));
endmodule

// File: rtl/halfpel_fir6.sv
// Six-tap half-pel interpolator. Sample window + fill count, then a two-stage
// pipe: S1 folds symmetric tap pairs, S2 combines, rounds and shifts. Output is
// unclipped signed DATAWIDTH+3 bits for the downstream clip stage.
module halfpel_fir6
  import fme_pkg::*;
#(
  parameter int DATAWIDTH = FME_PIX_W,
  parameter int ACCWIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic                   row_start,
  input  logic [DATAWIDTH-1:0]   in_pixel,
  output logic                   out_valid,
  output logic [DATAWIDTH+2:0]   out_value
);
  localparam int PW = DATAWIDTH + 1;
  localparam int OW = DATAWIDTH + 3;

  logic [FIR_TAPS-1:0][DATAWIDTH-1:0] win;
  logic [2:0]                         cnt;
  logic [PW-1:0]                      p0, p1, p2;
  // [0]: window just became/stays full, [1]: S1 holds result, [2]: out_valid
  logic [FIR_STAGES:0]                vld_pipe;
  logic                               acc, full_acc;
  logic signed [ACCWIDTH-1:0]         sum, rnd;

  assign acc      = enable & in_valid;
  // Count saturates at 6, so any non-row-start accept from 5+ fills the window.
  assign full_acc = acc & ~row_start & (cnt >= 3'(FIR_TAPS - 1));

  // Sample window and fill count; row_start drops the old row so none of it
  // can leak into the new row's results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win <= '0;
      cnt <= '0;
    end else if (acc) begin
      if (row_start) begin
        win <= {{((FIR_TAPS - 1) * DATAWIDTH){1'b0}}, in_pixel};
        cnt <= 3'd1;
      end else begin
        win <= {win[FIR_TAPS-2:0], in_pixel};
        if (cnt != 3'(FIR_TAPS)) cnt <= cnt + 3'd1;
      end
    end
  end

  // Valid shift register, frozen by stall like every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      vld_pipe <= '0;
    else if (enable) vld_pipe <= {vld_pipe[FIR_STAGES-1:0], full_acc};
  end

  // S1: fold the symmetric tap pairs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
    end else if (enable) begin
      p0 <= PW'(win[0]) + PW'(win[5]);
      p1 <= PW'(win[1]) + PW'(win[4]);
      p2 <= PW'(win[2]) + PW'(win[3]);
    end
  end

  fir6_mac #(.PW(PW), .AW(ACCWIDTH)) u_mac (
    .p0  (p0),
    .p1  (p1),
    .p2  (p2),
    .sum (sum)
  );

  assign rnd = sum + ACCWIDTH'(FIR_ROUND);

  // S2: round (floor via arithmetic shift); value holds between results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                    out_value <= '0;
    else if (enable && vld_pipe[1]) out_value <= OW'(rnd >>> FIR_SHIFT);
  end

  assign out_valid = vld_pipe[FIR_STAGES];
endmodule
